// File: rtl/comparator_pkg.sv
// Shared types and helpers for the comparator sweep checker: FSM states,
// the reference comparison function and the pair-count constant.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 2;
  localparam int NUM_PAIRS     = 1 << (2 * DEFAULT_WIDTH);

  function automatic int num_pairs(input int width);
    return 1 << (2 * width);
  endfunction

  // Returns {gt, eq, lt} for two unsigned operands (zero-extend narrower ones).
  function automatic logic [2:0] expected_flags(input logic [31:0] a, input logic [31:0] b);
    return {(a > b), (a == b), (a < b)};
  endfunction

endpackage

// File: rtl/comparator_sweep_checker.sv
// Exhaustive sweep engine: drives every (a, b) pair to an external magnitude
// comparator, samples its flags after SETTLE cycles and records failures.
module comparator_sweep_checker
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               a_gt_b_in,
  input  logic               a_eq_b_in,
  input  logic               a_lt_b_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    CNT_RELOAD = CW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   err_q, err_d;
  logic               fev_q, fev_d;
  logic [WIDTH-1:0]   fea_q, fea_d, feb_q, feb_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0]         obs_flags, exp_flags;
  logic               fail;

  assign obs_flags = {a_gt_b_in, a_eq_b_in, a_lt_b_in};
  assign exp_flags = expected_flags(32'(a_q), 32'(b_q));
  // Any bit difference fails, so non-one-hot flag patterns are caught too.
  assign fail      = (obs_flags != exp_flags);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      feb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      feb_q   <= feb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    feb_d   = feb_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = '0;
          b_d     = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          feb_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        if (fail) begin
          err_d = err_q + 1'b1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = a_q;
            feb_d = b_q;
          end
        end
        // b is the inner loop; the last pair leaves the operands in place.
        if (a_q == ALL_ONES && b_q == ALL_ONES) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          if (b_q == ALL_ONES) begin
            b_d = '0;
            a_d = a_q + 1'b1;
          end else begin
            b_d = b_q + 1'b1;
          end
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_a     = fea_q;
  assign first_err_b     = feb_q;

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Bench for comparator_sweep_checker: two instances (SETTLE=1 and SETTLE=3)
// driving a behavioural comparator with selectable faults.
module tb_comparator_sweep_checker;
  import comparator_pkg::*;

  localparam int W = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic start1, start3;
  logic [W-1:0] a1, b1, a3, b3, fea1, feb1, fea3, feb3;
  logic gt1, eq1, lt1, gt3, eq3, lt3;
  logic busy1, done1, pass1, fev1, busy3, done3, pass3, fev3;
  logic [2*W:0] err1, err3;

  // Comparator fault modes: 0 good, 1 gt/lt swapped, 2 eq stuck 0, 3 XOR mask per pair.
  int mode1, mode3;
  logic [2:0] mask1 [16];
  logic [2:0] mask3 [16];

  function automatic logic [2:0] comp_model(input int a, input int b, input int mode,
                                            input logic [2:0] mask);
    logic [2:0] good;
    good = {(a > b), (a == b), (a < b)};
    case (mode)
      1: return {good[0], good[1], good[2]};
      2: return {good[2], 1'b0, good[0]};
      3: return good ^ mask;
      default: return good;
    endcase
  endfunction

  always_comb {gt1, eq1, lt1} = comp_model(int'(a1), int'(b1), mode1, mask1[{a1, b1}]);
  always_comb {gt3, eq3, lt3} = comp_model(int'(a3), int'(b3), mode3, mask3[{a3, b3}]);

  comparator_sweep_checker #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
    .a_gt_b_in(gt1), .a_eq_b_in(eq1), .a_lt_b_in(lt1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_a(fea1), .first_err_b(feb1)
  );

  comparator_sweep_checker #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3),
    .a_gt_b_in(gt3), .a_eq_b_in(eq3), .a_lt_b_in(lt3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_valid(fev3), .first_err_a(fea3), .first_err_b(feb3)
  );

  // Output mux so one set of tasks serves either instance.
  int sel;
  logic busy_s, done_s, pass_s, fev_s;
  logic [31:0] err_s, fea_s, feb_s, a_s, b_s;
  always_comb begin
    busy_s = (sel == 3) ? busy3 : busy1;
    done_s = (sel == 3) ? done3 : done1;
    pass_s = (sel == 3) ? pass3 : pass1;
    fev_s  = (sel == 3) ? fev3  : fev1;
    err_s  = (sel == 3) ? 32'(err3) : 32'(err1);
    fea_s  = (sel == 3) ? 32'(fea3) : 32'(fea1);
    feb_s  = (sel == 3) ? 32'(feb3) : 32'(feb1);
    a_s    = (sel == 3) ? 32'(a3)   : 32'(a1);
    b_s    = (sel == 3) ? 32'(b3)   : 32'(b1);
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 3) start3 = v;
    else        start1 = v;
  endtask

  // Reference: walk all pairs in sweep order and collect the failure summary.
  task automatic model_sweep(input int s, input int settle);
    int errs, fa, fb;
    bit found;
    logic [2:0] obs, good;
    errs = 0; fa = 0; fb = 0; found = 0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        good = {(a > b), (a == b), (a < b)};
        obs = (s == 3) ? comp_model(a, b, mode3, mask3[a * (1 << W) + b])
                       : comp_model(a, b, mode1, mask1[a * (1 << W) + b]);
        if (obs != good) begin
          errs++;
          if (!found) begin found = 1; fa = a; fb = b; end
        end
      end
    end
    exp_q.push_back(32'(NUM_PAIRS * (settle + 1)));
    exp_q.push_back(32'(errs));
    exp_q.push_back(32'(found));
    exp_q.push_back(32'(fa));
    exp_q.push_back(32'(fb));
    exp_q.push_back(32'(errs == 0));
  endtask

  task automatic run_sweep(input int s, input int settle, input int extra_at);
    int cycles;
    sel = s;
    model_sweep(s, settle);
    @(negedge clk); set_start(s, 1'b1);
    @(negedge clk); set_start(s, 1'b0);
    check("start_busy", 32'(busy_s), 1);
    check("start_done", 32'(done_s), 0);
    check("start_err_clr", err_s, 0);
    check("start_fev_clr", 32'(fev_s), 0);
    cycles = 0;
    while (busy_s && cycles < 1000) begin
      cycles++;
      set_start(s, cycles == extra_at);
      @(negedge clk);
    end
    set_start(s, 1'b0);
    check("busy_cycles", 32'(cycles), exp_q.pop_front());
    check("done", 32'(done_s), 1);
    check("err_count", err_s, exp_q.pop_front());
    check("first_err_valid", 32'(fev_s), exp_q.pop_front());
    check("first_err_a", fea_s, exp_q.pop_front());
    check("first_err_b", feb_s, exp_q.pop_front());
    check("pass", 32'(pass_s), exp_q.pop_front());
    check("last_a", a_s, 3);
    check("last_b", b_s, 3);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic fill_random_mask(input int s);
    for (int i = 0; i < 16; i++) begin
      if (s == 3) mask3[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
      else        mask1[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    mode1 = 0; mode3 = 0; sel = 1;
    for (int i = 0; i < 16; i++) begin mask1[i] = 3'b0; mask3[i] = 3'b0; end
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_pass", 32'(pass1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_a3", 32'(a3), 0);
    check("rst_busy3", 32'(busy3), 0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(1, 1, 0);
    mode1 = 1;
    run_sweep(1, 1, 0);
    check("swap_err_const", 32'(err1), 12);
    check("swap_first_b", 32'(feb1), 1);
    mode1 = 0;
    run_sweep(1, 1, 0);
    mode1 = 2;
    run_sweep(1, 1, 0);
    check("eqstuck_err_const", 32'(err1), 4);
    mode1 = 0;
    run_sweep(3, 3, 10);
    check("settle3_pass", 32'(pass3), 1);

    for (int k = 0; k < 4; k++) begin
      int s;
      s = (k % 2 == 0) ? 1 : 3;
      if (s == 3) mode3 = 3; else mode1 = 3;
      fill_random_mask(s);
      run_sweep(s, (s == 3) ? 3 : 1, int'($urandom_range(0, 20)));
    end
    mode1 = 0; mode3 = 0;

    // asynchronous reset mid-sweep
    sel = 1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_a", 32'(a1), 0);
    check("arst_b", 32'(b1), 0);
    check("arst_busy", 32'(busy1), 0);
    check("arst_done", 32'(done1), 0);
    check("arst_pass", 32'(pass1), 0);
    check("arst_err", 32'(err1), 0);
    check("arst_fev", 32'(fev1), 0);
    check("arst_fea", 32'(fea1), 0);
    check("arst_feb", 32'(feb1), 0);
    @(negedge clk); rst = 1'b0;
    run_sweep(1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparator_sweep_checker.md
Name: comparator_sweep_checker

Overview:
Synthesizable exhaustive stimulus and check engine for the magnitude comparator (`a_gt_b` / `a_eq_b` / `a_lt_b` flags).
- Drives every (a, b) operand pair onto an external comparator and samples its three flags after a settle delay.
- Checks the flags against internally computed expected values and reports error count, first failing pair and pass/fail.
- Sits beside the comparator in on-chip self-test and FPGA bring-up builds. It replaces the hand-written vector list with a full sweep.

Parameters:
- WIDTH, 2, operand width in bits; a_out and b_out are WIDTH bits each.
- SETTLE, 1, cycles between driving a pair and sampling the flags; legal range is 1 or more.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous assert, active-high.
- start  input  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
- a_out  output  WIDTH  operand A driven to the comparator.
- b_out  output  WIDTH  operand B driven to the comparator.
- a_gt_b_in  input  1  comparator "greater" flag.
- a_eq_b_in  input  1  comparator "equal" flag.
- a_lt_b_in  input  1  comparator "less" flag.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or reset.
- pass  output  1  done and err_count equal to 0.
- err_count  output  2*WIDTH+1  number of failing pairs.
- first_err_valid  output  1  at least one failure has been recorded.
- first_err_a  output  WIDTH  a value of the first failing pair.
- first_err_b  output  WIDTH  b value of the first failing pair.

Behaviour:
- Reset (rst high, asynchronous), all outputs 0:
  - state goes to IDLE;
  - a_out, b_out, busy, done, pass, err_count, first_err_valid, first_err_a and first_err_b are all cleared;
  - the settle counter is cleared.
- States are IDLE, SETTLE, CHECK and DONE; all outputs are registered.
- IDLE or DONE with start high:
  - a_out and b_out go to 0;
  - err_count, first_err_valid, first_err_a and first_err_b are cleared;
  - done goes to 0 and busy goes to 1;
  - settle counter is loaded with SETTLE-1; next state is SETTLE.
- SETTLE:
  - a_out and b_out are held;
  - the counter decrements; when it reaches 0 the next state is CHECK.
  - Net effect: the pair is stable for SETTLE cycles before the sample.
- CHECK: sample the three flag inputs this cycle.
  - Expected flags: gt = (a_out > b_out), eq = (a_out == b_out), lt = (a_out < b_out), compared as unsigned.
  - A mismatch on any of the three bits is a failure. This includes non-one-hot flag patterns.
  - On a failure, err_count increments. If first_err_valid is 0, it is set to 1 and first_err_a/first_err_b capture the pair.
  - Ordering is b inner, a outer: b increments; when b is all-ones, b wraps to 0 and a increments.
  - If a and b are both all-ones, the next state is DONE. Otherwise the settle counter is reloaded and the next state is SETTLE.
- DONE:
  - busy is 0 and done is 1;
  - pass is 1 when err_count is 0;
  - a_out and b_out hold the last pair.
- start while busy is ignored and has no side effect.
- Latency: each pair takes SETTLE+1 cycles. busy stays high for exactly 2^(2*WIDTH)*(SETTLE+1) cycles after the accepted start edge.
- err_count cannot overflow: its maximum value is 2^(2*WIDTH), which fits in 2*WIDTH+1 bits.
- Reset mid-sweep aborts immediately to IDLE with all outputs cleared. No partial results are retained.
- Flag inputs are treated as synchronous to clk. Synchronizing them is the caller's responsibility.

Decomposition:
- Package comparator_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - a function returning the expected {gt, eq, lt} for two unsigned operands;
  - localparam NUM_PAIRS = 2^(2*WIDTH).
- No sub-module: the FSM, the operand counters, the settle counter and the error capture live in one module.
- The comparator under test is instantiated externally.

Test Plan:
- Correct comparator, WIDTH=2, SETTLE=1, start pulse:
  - busy is high for 32 cycles;
  - then done=1, pass=1, err_count=0, first_err_valid=0;
  - a_out and b_out end at 3 and 3.
- Comparator with gt and lt swapped: done with err_count=12, first_err_valid=1, first_err_a=0, first_err_b=1, pass=0.
- Comparator with eq stuck at 0: err_count=4, first error at (0,0), pass=0.
- SETTLE=3 with a correct model, including a second start pulse during the sweep:
  - busy is high for 64 cycles;
  - the extra start is ignored (no restart, no count change).
- rst asserted asynchronously at cycle 10 of a sweep: all outputs are 0 the same cycle. A following start completes a clean 32-cycle sweep with pass=1.
- Restart from DONE after the failing sweep, with the comparator now correct: err_count and first_err fields are cleared on start, and the sweep ends with pass=1.
